window_streamer: RTL and testbench

- Producer side of the 3x3 window interface consumed by the convolution stage.
- Accepts a raster-order grayscale pixel stream, one pixel per handshake.
- Holds the two previous image rows in line buffers and emits one packed 3x3 neighbourhood per accepted interior pixel, with valid/ready flow control.
- Sits between the image source or frame reader and the Gaussian/Sobel convolution.

---
 rtl/window_streamer.sv | 169 ++++++++++++++++
 tb/tb_window_streamer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_streamer.sv
// 3x3 neighbourhood generator: raster pixels in, one packed window per interior pixel out.
// Latency: 1 cycle from pixel accept to win_valid.
// Backpressure: pix_ready drops while a window is held unconsumed; a stalled window never blocks on itself.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   pix_in/pix_valid    raster-order input pixel and its qualifier
//   pix_sof             marks the accepted pixel as (0,0) of a new frame
//   pix_ready           combinational accept strobe: !win_valid || win_ready
//   win_out/win_valid   packed 3x3 window, row-major from top-left in the low bits
//   win_ready           consumer takes win_out
//   frame_done          single-cycle pulse after the last pixel of a frame is accepted
//   stall_cnt           (WINDOW_STALL_CNT_EN only) saturating count of stalled output cycles per frame
//
// Optional feature macro: WINDOW_STALL_CNT_EN
module window_streamer #(
  parameter int  COLDepth   = 8,
  parameter int  IMG_WIDTH  = 512,
  parameter int  IMG_HEIGHT = 512,
  localparam int Win_Size   = 9 * COLDepth
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COLDepth-1:0] pix_in,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  output logic [Win_Size-1:0] win_out,
  output logic                win_valid,
  input  logic                win_ready,
`ifdef WINDOW_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic                frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col, cur_col;
  logic [ROW_W-1:0]   row, cur_row;
  logic               accept, emit;
  logic               at_last_col, at_last_row, frame_end;

  // Line buffers: lb1 holds row-1, lb0 holds row-2. Contents need no reset;
  // rows 0 and 1 of every frame rewrite them before any window is emitted.
  logic [COLDepth-1:0] lb0 [IMG_WIDTH];
  logic [COLDepth-1:0] lb1 [IMG_WIDTH];
  logic [COLDepth-1:0] lb0_rd, lb1_rd;

  // win[r][c]: r=0 is the oldest row (top), c=2 the newest column (right).
  logic [COLDepth-1:0] win     [3][3];
  logic [COLDepth-1:0] win_nxt [3][3];
  logic [Win_Size-1:0] win_pack;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel is treated as (0,0) regardless of the counters.
  assign cur_col = pix_sof ? '0 : col;
  assign cur_row = pix_sof ? '0 : row;

  assign at_last_col = (cur_col == LAST_COL);
  assign at_last_row = (cur_row == LAST_ROW);
  assign frame_end   = at_last_col && at_last_row;

  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // STREAM is exactly "row >= 2"; an sof pixel is at row 0 and never emits.
  assign emit = accept && (state == STREAM) && !pix_sof && (col >= COL_W'(2));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb0_rd;
    win_nxt[1][2] = lb1_rd;
    win_nxt[2][2] = pix_in;
  end

  always_comb begin
    win_pack = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_pack[(r*3 + c)*COLDepth +: COLDepth] = win_nxt[r][c];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        // Last pixel of row 1 moves the raster onto row 2.
        if (accept && at_last_col && (cur_row == ROW_W'(1))) state_nxt = STREAM;
      end
      STREAM: begin
        if (accept && (pix_sof || frame_end)) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= lb1_rd;
      lb1[cur_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_out    <= '0;
      frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= accept && frame_end;
      if (accept) begin
        win <= win_nxt;
        if (at_last_col) begin
          col <= '0;
          row <= at_last_row ? '0 : cur_row + ROW_W'(1);
        end else begin
          col <= cur_col + COL_W'(1);
          row <= cur_row;
        end
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_out   <= win_pack;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef WINDOW_STALL_CNT_EN
  // Cleared at the edge that ends the frame_done cycle; a stall in that cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (frame_done) begin
      stall_cnt <= '0;
    end else if (win_valid && !win_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_streamer.sv
module tb_window_streamer;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int D    = 8;
  localparam int NPIX = W * H;

  typedef logic [0:NPIX-1][D-1:0] frame_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [D-1:0]   pix_in = '0;
  logic           pix_valid = 1'b0;
  logic           pix_sof = 1'b0;
  logic           pix_ready;
  logic [9*D-1:0] win_out;
  logic           win_valid;
  logic           win_ready = 1'b1;
  logic           frame_done;
`ifdef WINDOW_STALL_CNT_EN
  logic [15:0]    stall_cnt;
  logic [15:0]    stall_snap = '0;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard and monitor state
  logic [9*D-1:0] exp_q [$];
  logic [9*D-1:0] exp_w;
  logic [9*D-1:0] held;
  int  fd_cnt = 0, wins_seen = 0, stall_cycles = 0;
  int  pos_r = 0, pos_c = 0, ar = 0, ac = 0;
  bit  acc_pending = 0, exp_emit = 0, exp_last = 0, stall_prev = 0;

  window_streamer #(.COLDepth(D), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
`ifdef WINDOW_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic frame_t ramp_frame(input int base);
    frame_t f;
    for (int i = 0; i < NPIX; i++) f[i] = D'(base + i);
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NPIX; i++) f[i] = D'($urandom);
    return f;
  endfunction

  // Window whose bottom-right pixel is (r,c); byte k = pixel (r-2+k/3, c-2+k%3).
  function automatic logic [9*D-1:0] model_win(input frame_t f, input int r, input int c);
    logic [9*D-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3 + j)*D +: D] = f[(r - 2 + i)*W + (c - 2 + j)];
    return w;
  endfunction

  // Queue every window whose bottom-right pixel index is below 'upto'.
  task automatic expect_windows(input frame_t f, input int upto);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        if (r*W + c < upto) exp_q.push_back(model_win(f, r, c));
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (!reset) begin
      pos_r = 0; pos_c = 0; acc_pending = 0; stall_prev = 0;
    end else begin
      // Consequences of the rising edge just past.
      checks++;
      if (frame_done !== (acc_pending && exp_last))
        $display("FAIL frame_done_timing: got %b expected %b at %0t", frame_done, acc_pending && exp_last, $time);
      if (frame_done !== (acc_pending && exp_last)) errors++;
      if (acc_pending) begin
        checks++;
        if (win_valid !== exp_emit) begin
          errors++;
          $display("FAIL emit_after_accept: win_valid got %b expected %b for pixel (%0d,%0d)", win_valid, exp_emit, ar, ac);
        end
      end
      if (stall_prev) begin
        checks++;
        if (win_valid !== 1'b1 || win_out !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b win=%h expected valid=1 win=%h", win_valid, win_out, held);
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
      checks++;
      if (pix_ready !== (!win_valid || win_ready)) begin
        errors++;
        $display("FAIL pix_ready_rule: got %b expected %b", pix_ready, !win_valid || win_ready);
      end
      // Current cycle.
      if (win_valid && win_ready) begin
        wins_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got %h expected none", win_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (win_out !== exp_w) begin
            errors++;
            $display("FAIL window_value: got %h expected %h", win_out, exp_w);
          end
        end
      end
      stall_prev = win_valid && !win_ready;
      if (stall_prev) begin
        stall_cycles++;
        held = win_out;
        checks++;
        if (pix_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_stall: got %b expected 0", pix_ready);
        end
      end
      acc_pending = pix_valid && pix_ready;
      if (acc_pending) begin
        if (pix_sof) begin ar = 0; ac = 0; end
        else begin ar = pos_r; ac = pos_c; end
        exp_emit = (ar >= 2) && (ac >= 2);
        exp_last = (ar == H - 1) && (ac == W - 1);
`ifdef WINDOW_STALL_CNT_EN
        if (exp_last) stall_snap = stall_cnt;
`endif
        pos_c = ac + 1;
        pos_r = ar;
        if (pos_c == W) begin
          pos_c = 0;
          pos_r = (ar + 1 == H) ? 0 : ar + 1;
        end
      end
    end
  end

  // ---------------- drivers (inputs change 1 time unit after rising edge) ----------------
  task automatic send_pixel(input logic [D-1:0] v, input logic sof, input int gap_pct);
    int n;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      pix_valid = 1'b0;
      pix_sof   = 1'($urandom_range(1));
      pix_in    = D'($urandom);
      @(posedge clk); #1;
    end
    pix_in = v; pix_sof = sof; pix_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: pix_ready stuck at 0 for %0d cycles", n);
        break;
      end
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap_pct, input logic first_sof);
    for (int i = 0; i < NPIX; i++) send_pixel(f[i], first_sof && (i == 0), gap_pct);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (win_valid !== 1'b0)  begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    if (win_out !== '0)      begin errors++; $display("FAIL reset_win_out: got %h expected 0", win_out); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    if (pix_ready !== 1'b1)  begin errors++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready); end
`ifdef WINDOW_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int fd0, w0;
    frame_t f;
    f = ramp_frame(0);
    fd0 = fd_cnt; w0 = wins_seen;
    expect_windows(f, NPIX);
    send_frame(f, 0, 1'b0);
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0)   begin errors++; $display("FAIL basic_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 6) begin errors++; $display("FAIL basic_count: got %0d expected 6", wins_seen - w0); end
    if (fd_cnt - fd0 != 1)   begin errors++; $display("FAIL basic_frame_done: got %0d expected 1", fd_cnt - fd0); end
    exp_q.delete();
  endtask

  task automatic stall_ctl();
    int n;
    n = 0;
    while (win_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    win_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    win_ready = 1'b1;
  endtask

  task automatic test_stall();
    int fd0, w0, s0;
    frame_t f;
    f = ramp_frame(0);
    fd0 = fd_cnt; w0 = wins_seen; s0 = stall_cycles;
    expect_windows(f, NPIX);
    fork
      send_frame(f, 0, 1'b0);
      stall_ctl();
    join
    wait_drain();
    checks += 4;
    if (exp_q.size() != 0)        begin errors++; $display("FAIL stall_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 6)      begin errors++; $display("FAIL stall_count: got %0d expected 6", wins_seen - w0); end
    if (fd_cnt - fd0 != 1)        begin errors++; $display("FAIL stall_frame_done: got %0d expected 1", fd_cnt - fd0); end
    if (stall_cycles - s0 != 4)   begin errors++; $display("FAIL stall_cycles: got %0d expected 4", stall_cycles - s0); end
`ifdef WINDOW_STALL_CNT_EN
    checks++;
    if (stall_snap !== 16'd4) begin errors++; $display("FAIL stall_cnt_value: got %0d expected 4", stall_snap); end
`endif
    exp_q.delete();
  endtask

  task automatic test_gaps();
    int fd0, w0;
    bit done;
    frame_t f, g;
    f = ramp_frame(0);
    g = rand_frame();
    fd0 = fd_cnt; w0 = wins_seen;
    expect_windows(f, NPIX);
    send_frame(f, 50, 1'b0);
    expect_windows(g, NPIX);
    done = 0;
    fork
      begin send_frame(g, 50, 1'b0); done = 1; end
      begin
        while (!done) begin @(posedge clk); #1; win_ready = 1'($urandom_range(1)); end
        win_ready = 1'b1;
      end
    join
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0)    begin errors++; $display("FAIL gaps_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 12) begin errors++; $display("FAIL gaps_count: got %0d expected 12", wins_seen - w0); end
    if (fd_cnt - fd0 != 2)    begin errors++; $display("FAIL gaps_frame_done: got %0d expected 2", fd_cnt - fd0); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int fd0, w0;
    frame_t f1, f2;
    f1 = ramp_frame(0);
    f2 = ramp_frame(100);
    fd0 = fd_cnt; w0 = wins_seen;
    expect_windows(f1, NPIX);
    expect_windows(f2, NPIX);
    send_frame(f1, 0, 1'b0);
    send_frame(f2, 0, 1'b0);
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0)    begin errors++; $display("FAIL b2b_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", wins_seen - w0); end
    if (fd_cnt - fd0 != 2)    begin errors++; $display("FAIL b2b_frame_done: got %0d expected 2", fd_cnt - fd0); end
    exp_q.delete();
  endtask

  task automatic test_sof();
    int fd0, w0;
    frame_t f;
    f = ramp_frame(0);
    fd0 = fd_cnt; w0 = wins_seen;
    // Partial frame of 8 pixels, then resync: the 9th pixel carries sof.
    for (int i = 0; i < 8; i++) send_pixel(D'(200 + i), 1'b0, 0);
    expect_windows(f, NPIX);
    send_frame(f, 0, 1'b1);
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0)   begin errors++; $display("FAIL sof_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 6) begin errors++; $display("FAIL sof_count: got %0d expected 6", wins_seen - w0); end
    if (fd_cnt - fd0 != 1)   begin errors++; $display("FAIL sof_frame_done: got %0d expected 1", fd_cnt - fd0); end
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    int fd0, w0;
    frame_t f, g;
    g = rand_frame();
    f = ramp_frame(0);
    // Pixels 0..17 reach (3,2); its window is valid when reset hits and must vanish.
    expect_windows(g, 17);
    for (int i = 0; i < 18; i++) send_pixel(g[i], 1'b0, 0);
    #1;
    reset = 1'b0;
    #1;
    checks += 4;
    if (win_valid !== 1'b0)  begin errors++; $display("FAIL midreset_win_valid: got %b expected 0", win_valid); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_frame_done: got %b expected 0", frame_done); end
    if (pix_ready !== 1'b1)  begin errors++; $display("FAIL midreset_pix_ready: got %b expected 1", pix_ready); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL midreset_prior_windows: got %0d left expected 0", exp_q.size()); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fd0 = fd_cnt; w0 = wins_seen;
    expect_windows(f, NPIX);
    send_frame(f, 0, 1'b0);
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0)   begin errors++; $display("FAIL postreset_missing: got %0d left expected 0", exp_q.size()); end
    if (wins_seen - w0 != 6) begin errors++; $display("FAIL postreset_count: got %0d expected 6", wins_seen - w0); end
    if (fd_cnt - fd0 != 1)   begin errors++; $display("FAIL postreset_frame_done: got %0d expected 1", fd_cnt - fd0); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_sof();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
